// File: rtl/fft_out_sort_ctrl.sv
// rtl/fft_out_sort_ctrl.sv - fill/drain sequencer for the 64-point FFT output reorder store
// Writes land at natural-order locations during FILL; DRAIN reads back 0..63 and tags the stream.
module fft_out_sort_ctrl #(
   parameter int DIGIT_REV = 1,
   parameter int READ_LAT  = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] w_en,
   output logic [2:0] w_addr,
   output logic [7:0] r_en,
   output logic [2:0] r_addr,
   output logic       out_valid,
   output logic [5:0] out_index,
   output logic       out_last,
   output logic       overflow
);

   typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

   state_t     state_q, state_d;
   logic [5:0] wr_cnt_q, wr_cnt_d;
   logic [5:0] rd_cnt_q, rd_cnt_d;
   logic       overflow_q, overflow_d;
   logic       dly_valid_q, dly_valid_d;
   logic [5:0] dly_index_q, dly_index_d;
   logic       dly_last_q, dly_last_d;

   logic       acc;
   logic [2:0] w_bank;
   logic       iss_valid;
   logic       iss_last;

   always_comb begin
      in_ready = (state_q == FILL);
      acc      = in_valid & in_ready;

      // Digit reversal only changes which wr_cnt digit selects the bank.
      if (DIGIT_REV == 1) begin
         w_bank = wr_cnt_q[2:0];
         w_addr = wr_cnt_q[5:3];
      end else begin
         w_bank = wr_cnt_q[5:3];
         w_addr = wr_cnt_q[2:0];
      end
      w_en = acc ? (8'h01 << w_bank) : 8'h00;

      iss_valid = (state_q == DRAIN);
      iss_last  = iss_valid & (rd_cnt_q == 6'd63);
      r_en      = iss_valid ? (8'h01 << rd_cnt_q[5:3]) : 8'h00;
      r_addr    = iss_valid ? rd_cnt_q[2:0] : 3'd0;

      state_d  = state_q;
      wr_cnt_d = wr_cnt_q;
      rd_cnt_d = rd_cnt_q;
      if (state_q == FILL) begin
         if (acc) begin
            wr_cnt_d = wr_cnt_q + 6'd1;
            if (wr_cnt_q == 6'd63) state_d = DRAIN;
         end
      end else begin
         rd_cnt_d = rd_cnt_q + 6'd1;
         if (rd_cnt_q == 6'd63) state_d = FILL;
      end

      overflow_d  = overflow_q | (in_valid & ~in_ready);
      dly_valid_d = iss_valid;
      dly_index_d = rd_cnt_q;
      dly_last_d  = iss_last;

      if (READ_LAT == 0) begin
         out_valid = iss_valid;
         out_index = rd_cnt_q;
         out_last  = iss_last;
      end else begin
         out_valid = dly_valid_q;
         out_index = dly_index_q;
         out_last  = dly_last_q;
      end
      overflow = overflow_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= FILL;
         wr_cnt_q    <= 6'd0;
         rd_cnt_q    <= 6'd0;
         overflow_q  <= 1'b0;
         dly_valid_q <= 1'b0;
         dly_index_q <= 6'd0;
         dly_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_cnt_q    <= wr_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
         overflow_q  <= overflow_d;
         dly_valid_q <= dly_valid_d;
         dly_index_q <= dly_index_d;
         dly_last_q  <= dly_last_d;
      end
   end

endmodule

// File: tb/tb_fft_out_sort_ctrl.sv
// tb/tb_fft_out_sort_ctrl.sv - randomized check of fft_out_sort_ctrl against a frame-level model
// Three instances (DR1/RL1, DR0/RL1, DR1/RL0) share stimulus, each with its own store model.
module tb_fft_out_sort_ctrl;

   logic clk = 1'b0;
   logic rst;
   logic in_valid;
   logic [5:0] din;

   logic       in_ready_a, in_ready_b, in_ready_c;
   logic [7:0] w_en_a, w_en_b, w_en_c, r_en_a, r_en_b, r_en_c;
   logic [2:0] w_addr_a, w_addr_b, w_addr_c, r_addr_a, r_addr_b, r_addr_c;
   logic       out_valid_a, out_valid_b, out_valid_c;
   logic [5:0] out_index_a, out_index_b, out_index_c;
   logic       out_last_a, out_last_b, out_last_c;
   logic       overflow_a, overflow_b, overflow_c;

   always #5 clk = ~clk;

   fft_out_sort_ctrl #(.DIGIT_REV(1), .READ_LAT(1)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
      .w_en(w_en_a), .w_addr(w_addr_a), .r_en(r_en_a), .r_addr(r_addr_a),
      .out_valid(out_valid_a), .out_index(out_index_a), .out_last(out_last_a),
      .overflow(overflow_a));

   fft_out_sort_ctrl #(.DIGIT_REV(0), .READ_LAT(1)) u_dr0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
      .w_en(w_en_b), .w_addr(w_addr_b), .r_en(r_en_b), .r_addr(r_addr_b),
      .out_valid(out_valid_b), .out_index(out_index_b), .out_last(out_last_b),
      .overflow(overflow_b));

   fft_out_sort_ctrl #(.DIGIT_REV(1), .READ_LAT(0)) u_rl0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c),
      .w_en(w_en_c), .w_addr(w_addr_c), .r_en(r_en_c), .r_addr(r_addr_c),
      .out_valid(out_valid_c), .out_index(out_index_c), .out_last(out_last_c),
      .overflow(overflow_c));

   function automatic logic [2:0] oh3(input logic [7:0] v);
      oh3 = 3'd0;
      for (int i = 0; i < 8; i++) if (v[i]) oh3 = 3'(i);
   endfunction

   // Store models: 8 banks x 8 entries, registered read for a/b, combinational for c.
   logic [5:0] mem_a [64];
   logic [5:0] mem_b [64];
   logic [5:0] mem_c [64];
   logic [5:0] rd_a, rd_b, rd_c;

   always @(posedge clk) begin
      for (int b = 0; b < 8; b++) begin
         if (w_en_a[b]) mem_a[{3'(b), w_addr_a}] <= din;
         if (w_en_b[b]) mem_b[{3'(b), w_addr_b}] <= din;
         if (w_en_c[b]) mem_c[{3'(b), w_addr_c}] <= din;
      end
      if (r_en_a != 8'h00) rd_a <= mem_a[{oh3(r_en_a), r_addr_a}];
      if (r_en_b != 8'h00) rd_b <= mem_b[{oh3(r_en_b), r_addr_b}];
   end
   assign rd_c = mem_c[{oh3(r_en_c), r_addr_c}];

   int checks = 0;
   int errors = 0;
   int wen_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Frame-level reference: accepted-sample count, drain position, previous issue record.
   int m_acc, m_p;
   bit m_draining, m_ovf;
   bit pv, pl;
   int pp;

   function automatic int rev(input int k);
      return (k % 8) * 8 + k / 8;
   endfunction

   task automatic model_reset();
      m_acc = 0; m_p = 0; m_draining = 0; m_ovf = 0;
      pv = 0; pp = 0; pl = 0;
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      rst = 1'b1;
      #2;
      chk("rst_in_ready", 32'(in_ready_a), 1);
      chk("rst_w_en", 32'(w_en_a), 0);
      chk("rst_w_addr", 32'(w_addr_a), 0);
      chk("rst_r_en", 32'(r_en_a), 0);
      chk("rst_r_addr", 32'(r_addr_a), 0);
      chk("rst_out_valid", 32'(out_valid_a), 0);
      chk("rst_out_index", 32'(out_index_a), 0);
      chk("rst_out_last", 32'(out_last_a), 0);
      chk("rst_overflow", 32'(overflow_a), 0);
      chk("rst_out_valid_rl0", 32'(out_valid_c), 0);
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic cycle(input bit v);
      bit ready, acc;
      int wen_dr1, wadr_dr1, wen_dr0, wadr_dr0, ren, radr;
      in_valid = v;
      din = 6'(m_acc);
      ready = !m_draining;
      acc = v && ready;
      wadr_dr1 = m_acc / 8;
      wen_dr1  = acc ? (1 << (m_acc % 8)) : 0;
      wadr_dr0 = m_acc % 8;
      wen_dr0  = acc ? (1 << (m_acc / 8)) : 0;
      ren  = m_draining ? (1 << (m_p / 8)) : 0;
      radr = m_draining ? (m_p % 8) : 0;
      @(negedge clk);
      if (w_en_a != 8'h00) wen_cnt++;
      chk("in_ready", 32'(in_ready_a), 32'(ready));
      chk("in_ready_dr0", 32'(in_ready_b), 32'(ready));
      chk("in_ready_rl0", 32'(in_ready_c), 32'(ready));
      chk("w_en", 32'(w_en_a), wen_dr1);
      chk("w_addr", 32'(w_addr_a), wadr_dr1);
      chk("w_en_dr0", 32'(w_en_b), wen_dr0);
      chk("w_addr_dr0", 32'(w_addr_b), wadr_dr0);
      chk("r_en", 32'(r_en_a), ren);
      chk("r_addr", 32'(r_addr_a), radr);
      chk("r_en_rl0", 32'(r_en_c), ren);
      chk("out_valid", 32'(out_valid_a), 32'(pv));
      chk("out_index", 32'(out_index_a), pp);
      chk("out_last", 32'(out_last_a), 32'(pl));
      chk("out_valid_dr0", 32'(out_valid_b), 32'(pv));
      chk("out_index_dr0", 32'(out_index_b), pp);
      chk("out_valid_rl0", 32'(out_valid_c), 32'(m_draining));
      chk("out_index_rl0", 32'(out_index_c), m_draining ? m_p : 0);
      chk("out_last_rl0", 32'(out_last_c), 32'(m_draining && m_p == 63));
      chk("overflow", 32'(overflow_a), 32'(m_ovf));
      chk("overflow_rl0", 32'(overflow_c), 32'(m_ovf));
      if (pv) begin
         chk("data", 32'(rd_a), rev(pp));
         chk("data_dr0", 32'(rd_b), pp);
      end
      if (m_draining) chk("data_rl0", 32'(rd_c), rev(m_p));
      // advance the reference by one clock
      if (v && !ready) m_ovf = 1;
      pv = m_draining;
      pp = m_draining ? m_p : 0;
      pl = m_draining && m_p == 63;
      if (m_draining) begin
         if (m_p == 63) begin m_draining = 0; m_p = 0; end
         else m_p++;
      end else if (acc) begin
         if (m_acc == 63) begin m_acc = 0; m_draining = 1; m_p = 0; end
         else m_acc++;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      din = 6'd0;
      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      // back-to-back frame then full drain
      for (int i = 0; i < 64; i++) cycle(1'b1);
      for (int i = 0; i < 66; i++) cycle(1'b0);

      // ~50% duty gaps; w_en must fire exactly 64 times before DRAIN
      wen_cnt = 0;
      for (int g = 0; g < 2000 && !m_draining; g++) cycle(1'($urandom_range(0, 1)));
      chk("wen_fires", wen_cnt, 64);
      for (int i = 0; i < 66; i++) cycle(1'b0);

      // reset after 30 accepts, then a clean frame
      for (int i = 0; i < 30; i++) cycle(1'b1);
      do_reset();
      for (int i = 0; i < 64; i++) cycle(1'b1);
      for (int i = 0; i < 66; i++) cycle(1'b0);

      // in_valid held through DRAIN, next frame still starts at 0
      for (int i = 0; i < 200; i++) cycle(1'b1);
      for (int i = 0; i < 70; i++) cycle(1'b0);

      // free-running random traffic
      for (int i = 0; i < 400; i++) cycle(1'($urandom_range(0, 1)));

      do_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
